// File: rtl/router_port_tx.sv
// Serial source driver for one router input port: address, padding, then LSB-first payload.
// Optional ROUTER_TX_PARITY_EN appends an even-parity bit after every payload word.
module router_port_tx #(
  parameter int unsigned PAD_CYCLES = 1,
  parameter int unsigned DATA_W     = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [3:0]        s_addr,
  input  logic              s_last,
  output logic              din_o,
  output logic              frame_n_o,
  output logic              valid_n_o,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
`ifdef ROUTER_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_PAD, ST_DATA, ST_PAR, ST_STALL, ST_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        pad_q, pad_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [3:0]        addr_q, addr_d;
  logic              last_q, last_d;

  logic din_q, frame_n_q, valid_n_q, s_ready_q, busy_q;
  logic din_d, frame_n_d, valid_n_d, s_ready_d, busy_d;

  logic xfer, last_bit, word_done;
  logic [3:0]        addr_sh;
  logic [DATA_W-1:0] word_sh;

  assign xfer      = s_valid && s_ready_q;
  assign last_bit  = (cnt_q == CNT_W'(DATA_W - 1));
  assign word_done = (state_q == ST_DATA && last_bit && !PARITY_EN) || (state_q == ST_PAR);

  // State, counters, captured word and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pad_q     <= '0;
      word_q    <= '0;
      addr_q    <= '0;
      last_q    <= 1'b0;
      din_q     <= 1'b0;
      frame_n_q <= 1'b1;
      valid_n_q <= 1'b1;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pad_q     <= pad_d;
      word_q    <= word_d;
      addr_q    <= addr_d;
      last_q    <= last_d;
      din_q     <= din_d;
      frame_n_q <= frame_n_d;
      valid_n_q <= valid_n_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pad_d   = pad_q;
    word_d  = word_q;
    addr_d  = addr_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d = ST_ADDR;
          cnt_d   = '0;
          word_d  = s_data;
          addr_d  = s_addr;
          last_d  = s_last;
        end
      end
      ST_ADDR: begin
        if (cnt_q == CNT_W'(3)) begin
          cnt_d   = '0;
          pad_d   = '0;
          state_d = (PAD_CYCLES > 0) ? ST_PAD : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PAD: begin
        if (pad_q == 4'(PAD_CYCLES - 1)) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end else begin
          pad_d = pad_q + 4'd1;
        end
      end
      ST_DATA: begin
        if (!last_bit) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (PARITY_EN) begin
          state_d = ST_PAR;
          cnt_d   = '0;
        end
      end
      ST_STALL: begin
        if (xfer) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          word_d  = s_data;
          last_d  = s_last;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // End of a word: close the frame, chain the next word, or wait for it
    if (word_done) begin
      cnt_d = '0;
      if (last_q) begin
        state_d = ST_GAP;
      end else if (xfer) begin
        state_d = ST_DATA;
        word_d  = s_data;
        last_d  = s_last;
      end else begin
        state_d = ST_STALL;
      end
    end
  end

  // Output values for the upcoming cycle, decoded from the next state
  always_comb begin
    din_d     = 1'b0;
    frame_n_d = 1'b0;
    valid_n_d = 1'b1;
    s_ready_d = 1'b0;
    busy_d    = (state_d != ST_IDLE);
    addr_sh   = addr_d << cnt_d[1:0];
    word_sh   = word_d >> cnt_d;
    case (state_d)
      ST_IDLE: begin
        frame_n_d = 1'b1;
        s_ready_d = 1'b1;
      end
      ST_ADDR: din_d = addr_sh[3];
      ST_PAD:  din_d = 1'b1;
      ST_DATA: begin
        din_d     = word_sh[0];
        valid_n_d = 1'b0;
        s_ready_d = (cnt_d == CNT_W'(DATA_W - 1)) && !last_d && !PARITY_EN;
      end
      ST_PAR: begin
        din_d     = ^word_d;
        valid_n_d = 1'b0;
        s_ready_d = !last_d;
      end
      ST_STALL: s_ready_d = 1'b1;
      ST_GAP:   frame_n_d = 1'b1;
      default:  frame_n_d = 1'b1;
    endcase
  end

  assign din_o     = din_q;
  assign frame_n_o = frame_n_q;
  assign valid_n_o = valid_n_q;
  assign s_ready   = s_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_router_port_tx.sv
// Directed self-checking bench for router_port_tx (DATA_W=8, PAD_CYCLES=1).
module tb_router_port_tx;

  localparam int DW  = 8;
  localparam int PAD = 1;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data  = '0;
  logic [3:0]    s_addr  = '0;
  logic          s_last  = 1'b0;
  logic          din_o, frame_n_o, valid_n_o, busy;

  int total = 0;
  int bad   = 0;
  int rdy_cnt = 0;
  bit cnt_en  = 1'b0;

  router_port_tx #(.PAD_CYCLES(PAD), .DATA_W(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_addr(s_addr), .s_last(s_last),
    .din_o(din_o), .frame_n_o(frame_n_o), .valid_n_o(valid_n_o), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (cnt_en && s_ready) rdy_cnt++;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Check {din, frame_n, valid_n} for the current cycle, then advance one cycle
  task automatic cyc(input string tag, input logic [2:0] exp);
    chk(tag, 16'({din_o, frame_n_o, valid_n_o}), 16'(exp));
    step();
  endtask

  task automatic exp_hdr(input string tag, input logic [3:0] a);
    for (int i = 3; i >= 0; i--) cyc(tag, {a[i], 2'b01});
    for (int i = 0; i < PAD; i++) cyc(tag, 3'b101);
  endtask

  task automatic exp_word(input string tag, input logic [DW-1:0] w);
    for (int i = 0; i < DW; i++) cyc(tag, {w[i], 2'b00});
`ifdef ROUTER_TX_PARITY_EN
    cyc(tag, {^w, 2'b00});
`endif
  endtask

  task automatic start(input logic [3:0] a, input logic [DW-1:0] d, input logic l);
    s_valid = 1'b1; s_addr = a; s_data = d; s_last = l;
    step();
    s_valid = 1'b0; s_addr = 4'hF; s_data = 8'h5C; s_last = ~l;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [12:0] t1_seq;
    // Reset held for two cycles
    step(); step();
    chk("rst_out", 16'({din_o, frame_n_o, valid_n_o}), 16'(3'b011));
    chk("rst_rdy", 16'(s_ready), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    reset_n = 1'b1;
    step();
    chk("rel_rdy", 16'(s_ready), 16'd1);

    // Single word: addr A, data 35; addr 1010, pad 1, data LSB-first 10101100
    t1_seq = 13'b1010_1_10101100;
    start(4'hA, 8'h35, 1'b1);
    chk("t1_busy", 16'(busy), 16'd1);
    for (int i = 12; i >= 0; i--) begin
      if (i == 0) chk("t1_rdy_last", 16'(s_ready), 16'd0);
      cyc("t1_bit", {t1_seq[i], 1'b0, (i >= 8) ? 1'b1 : 1'b0});
    end
    chk("t1_gap_busy", 16'(busy), 16'd1);
    cyc("t1_gap", 3'b011);
    chk("t1_idle_busy", 16'(busy), 16'd0);
    chk("t1_idle_rdy", 16'(s_ready), 16'd1);

    // Back-to-back FF then 00 with s_valid held high
    s_valid = 1'b1; s_addr = 4'h3; s_data = 8'hFF; s_last = 1'b0;
    step();
    s_addr = 4'hF; s_data = 8'h00; s_last = 1'b1;
    rdy_cnt = 0; cnt_en = 1'b1;
    exp_hdr("t2_hdr", 4'h3);
    exp_word("t2_w0", 8'hFF);
    s_valid = 1'b0; s_data = 8'hA5;
    exp_word("t2_w1", 8'h00);
    cnt_en = 1'b0;
    chk("t2_rdy_pulses", 16'(rdy_cnt), 16'd1);
    cyc("t2_gap", 3'b011);

    // Starvation: three STALL cycles between words
    start(4'h5, 8'hC3, 1'b0);
    exp_hdr("t3_hdr", 4'h5);
    exp_word("t3_w0", 8'hC3);
    chk("t3_stall_rdy", 16'(s_ready), 16'd1);
    chk("t3_stall_busy", 16'(busy), 16'd1);
    cyc("t3_stall1", 3'b001);
    cyc("t3_stall2", 3'b001);
    chk("t3_stall3", 16'({din_o, frame_n_o, valid_n_o}), 16'(3'b001));
    s_valid = 1'b1; s_data = 8'h5A; s_last = 1'b1;
    step();
    s_valid = 1'b0; s_data = 8'h00;
    exp_word("t3_w1", 8'h5A);
    cyc("t3_gap", 3'b011);

    // Reset during data bit 3, then a clean packet
    start(4'h9, 8'h0F, 1'b1);
    exp_hdr("t4_hdr", 4'h9);
    for (int i = 0; i < 3; i++) cyc("t4_bit", 3'b100);
    chk("t4_bit3", 16'({din_o, frame_n_o, valid_n_o}), 16'(3'b100));
    reset_n = 1'b0;
    #1;
    chk("t4_rst_out", 16'({din_o, frame_n_o, valid_n_o}), 16'(3'b011));
    chk("t4_rst_rdy", 16'(s_ready), 16'd0);
    chk("t4_rst_busy", 16'(busy), 16'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("t4_rel_rdy", 16'(s_ready), 16'd1);
    start(4'h6, 8'h81, 1'b1);
    exp_hdr("t4_hdr2", 4'h6);
    exp_word("t4_w", 8'h81);
    cyc("t4_gap", 3'b011);

`ifdef ROUTER_TX_PARITY_EN
    // Data 07: bits 1,1,1,0,0,0,0,0 then parity 1
    start(4'h2, 8'h07, 1'b1);
    exp_hdr("t5_hdr", 4'h2);
    for (int i = 0; i < 3; i++) cyc("t5_bit", 3'b100);
    for (int i = 0; i < 5; i++) cyc("t5_bit", 3'b000);
    cyc("t5_par", 3'b100);
    cyc("t5_gap", 3'b011);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
